sc_lives_levels_counter: RTL and testbench
==========================================

Name: sc_lives_levels_counter

Overview:
- Downstream datapath stage of the general Frogger state machine.
- Consumes its active-low life-lost and level-up strobes and keeps the lives and current-level counts.
- Returns the registered comparator flags COMPARATOR_LIVES (no lives left) and COMPARATOR_LEVELS (final level reached) that the FSM branches on.
- Adds a post-death holdoff window so one collision held for many cycles costs exactly one life.

Parameters:
- LIVES_INIT, 3, lives loaded at reset/clear; must be ≤ 2^LIVES_W-1.
- LEVELS_MAX, 4, level index at which COMPARATOR_LEVELS asserts; must be ≤ 2^LEVEL_W-1.
- LIVES_W, 3, width of lives count.
- LEVEL_W, 3, width of level count.
- HOLDOFF_CYCLES, 8, cycles after an accepted life decrement during which further decrements are dropped; 0 disables. Synthesis uses 25_000_000.

Ports:
- SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock, 50 MHz; all state updates on its rising edge.
- SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_LIVESLEVELS_clear_InLow  in  1  synchronous clear to initial values, driven from the FSM reset state.
- SC_LIVESLEVELS_livesDec_InLow  in  1  life-lost request, active-low, level held for ≥1 cycle.
- SC_LIVESLEVELS_levelInc_InLow  in  1  level-up request, active-low, level held for ≥1 cycle.
- SC_LIVESLEVELS_lives_Out  out  LIVES_W  current lives.
- SC_LIVESLEVELS_level_Out  out  LEVEL_W  current level index, starting at 0.
- SC_STATEMACHINEGENERAL_COMPARATOR_LIVES  out  1  high when lives == 0.
- SC_STATEMACHINEGENERAL_COMPARATOR_LEVELS  out  1  high when level == LEVELS_MAX.
- SC_LIVESLEVELS_holdoff_Out  out  1  high while the holdoff window is active.

Behaviour:
- Async reset values:
  - lives = LIVES_INIT, level = 0, holdoff counter = 0.
  - COMPARATOR_LIVES = (LIVES_INIT == 0), COMPARATOR_LEVELS = (LEVELS_MAX == 0).
  - Edge-history flops = 1 (inactive).
- Edge detection: each strobe has a history flop that samples the input every cycle, including during clear.
  - Event = history 1 and input 0, i.e. the first low cycle only.
  - A strobe held low counts once. A strobe already low when reset or clear releases does not count.
- Latency: counters and flags update at the clock edge that ends the first low cycle (1-cycle latency).
- Flags are registered from the next-state counter values, so they are never a cycle behind the counts.
- Life decrement is accepted when dec event && lives != 0 && holdoff counter == 0.
  - lives <= lives-1.
  - Holdoff counter <= HOLDOFF_CYCLES.
- Holdoff counter decrements by 1 per cycle while nonzero. holdoff_Out = (counter != 0), registered.
- Dec events during holdoff are dropped, not queued.
- Lives saturate at 0: a dec event at 0 is ignored and no holdoff starts.
- Level increment: inc event && level != LEVELS_MAX → level <= level+1. At LEVELS_MAX the event is ignored (no wrap).
- Simultaneous dec and inc events in the same cycle: both are evaluated and applied independently.
- Clear (clear_InLow = 0, sampled synchronously) has priority over all events:
  - Loads the reset values, except the history flops keep sampling.
  - A held clear holds those values.
- No arithmetic wrap anywhere. Counters use plain unsigned compare against the parameters.

Decomposition:
- Shared package sc_frogger_pkg:
  - LIVES_INIT, LEVELS_MAX, LIVES_W, LEVEL_W.
  - HOLDOFF_CYCLES_SIM / HOLDOFF_CYCLES_SYN.
  - Holdoff counter width via $clog2(HOLDOFF_CYCLES+1).
- One sub-module, sc_falling_edge_detect (history flop + event output), instantiated twice: livesDec and levelInc.
- Counters, holdoff and flag registers stay in the top module.

Test Plan:
- Reset pulse then release: lives=3, level=0, COMP_LIVES=0, COMP_LEVELS=0, holdoff=0 on the first cycle after release.
- livesDec low for 20 cycles: lives=2 one edge after the first low cycle, holdoff high for exactly 8 cycles, no further decrement.
- Three dec pulses spaced 10 cycles apart, then a fourth: lives 3→2→1→0, COMP_LIVES rises with lives=0 on the same edge, fourth pulse leaves lives=0 and holdoff=0.
- Dec pulse at cycle 2 after a prior accepted dec (inside holdoff): dropped, lives unchanged. The same pulse at cycle 9 is accepted.
- Five single-cycle levelInc pulses: level 1,2,3,4,4; COMP_LEVELS=1 from the edge that loads 4. Simultaneous inc and dec applied together (e.g. level 2→3 and lives 3→2).
- Clear held 3 cycles with livesDec low throughout, then clear released with livesDec still low: values reinitialised and no decrement on release. Async reset asserted mid-holdoff: all outputs return to reset values immediately.

Source files
------------

// File: rtl/sc_frogger_pkg.sv
// Shared constants for the Frogger lives/levels datapath.
// Sizes, initial values and holdoff lengths for sim and synthesis.
package sc_frogger_pkg;

  localparam int FROG_LIVES_INIT = 3;
  localparam int FROG_LEVELS_MAX = 4;
  localparam int FROG_LIVES_W    = 3;
  localparam int FROG_LEVEL_W    = 3;

  localparam int FROG_HOLDOFF_CYCLES_SIM = 8;
  localparam int FROG_HOLDOFF_CYCLES_SYN = 25_000_000;

  // Holdoff counter width; a disabled holdoff still gets one bit
  // so the register never collapses to zero width.
  function automatic int hold_w(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sc_falling_edge_detect.sv
// Falling-edge detector for an active-low strobe.
// Ports: clock, async active-high reset, strobe in, one-cycle event out.
module sc_falling_edge_detect (
  input  logic SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic SC_EDGE_strobe_InLow,
  output logic SC_EDGE_event_Out
);

  logic hist_q;

  // History resets inactive and samples every cycle, clear or not.
  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or
              posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh)
      hist_q <= 1'b1;
    else
      hist_q <= SC_EDGE_strobe_InLow;
  end

  assign SC_EDGE_event_Out = hist_q & ~SC_EDGE_strobe_InLow;

endmodule

// File: rtl/sc_lives_levels_counter.sv
// Lives / level counters with post-death holdoff for the Frogger FSM.
// Ports: clock, async reset, active-low clear/dec/inc, counts, flags, holdoff.
module sc_lives_levels_counter
  import sc_frogger_pkg::*;
#(
  parameter int LIVES_INIT     = FROG_LIVES_INIT,
  parameter int LEVELS_MAX     = FROG_LEVELS_MAX,
  parameter int LIVES_W        = FROG_LIVES_W,
  parameter int LEVEL_W        = FROG_LEVEL_W,
  parameter int HOLDOFF_CYCLES = FROG_HOLDOFF_CYCLES_SIM
) (
  input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic               SC_LIVESLEVELS_clear_InLow,
  input  logic               SC_LIVESLEVELS_livesDec_InLow,
  input  logic               SC_LIVESLEVELS_levelInc_InLow,
  output logic [LIVES_W-1:0] SC_LIVESLEVELS_lives_Out,
  output logic [LEVEL_W-1:0] SC_LIVESLEVELS_level_Out,
  output logic               SC_STATEMACHINEGENERAL_COMPARATOR_LIVES,
  output logic               SC_STATEMACHINEGENERAL_COMPARATOR_LEVELS,
  output logic               SC_LIVESLEVELS_holdoff_Out
);

  localparam int HW = hold_w(HOLDOFF_CYCLES);

  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVELS_MAX);
  localparam logic [HW-1:0]      HOLD_LD   = HW'(HOLDOFF_CYCLES);

  localparam logic CL_RST = (LIVES_INIT == 0);
  localparam logic CV_RST = (LEVELS_MAX == 0);

  logic dec_ev;
  logic inc_ev;

  logic [LIVES_W-1:0] lives_q;
  logic [LIVES_W-1:0] lives_d;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_d;

  logic cl_q;
  logic cv_q;
  logic ho_q;

  logic dec_ok;
  logic inc_ok;

  sc_falling_edge_detect u_dec_edge (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .SC_EDGE_strobe_InLow                (SC_LIVESLEVELS_livesDec_InLow),
    .SC_EDGE_event_Out                   (dec_ev)
  );

  sc_falling_edge_detect u_inc_edge (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .SC_EDGE_strobe_InLow                (SC_LIVESLEVELS_levelInc_InLow),
    .SC_EDGE_event_Out                   (inc_ev)
  );

  // Saturating at 0 also means a dead player never arms the holdoff.
  assign dec_ok = dec_ev && (lives_q != '0) && (hold_q == '0);
  assign inc_ok = inc_ev && (level_q != LVL_MAX);

  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    hold_d  = hold_q;
    if (!SC_LIVESLEVELS_clear_InLow) begin
      lives_d = LIVES_RST;
      level_d = '0;
      hold_d  = '0;
    end else begin
      if (dec_ok) begin
        lives_d = lives_q - 1'b1;
        hold_d  = HOLD_LD;
      end else if (hold_q != '0) begin
        hold_d  = hold_q - 1'b1;
      end
      if (inc_ok)
        level_d = level_q + 1'b1;
    end
  end

  // Flags come from next-state values so they land with the counts.
  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or
              posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      lives_q <= LIVES_RST;
      level_q <= '0;
      hold_q  <= '0;
      cl_q    <= CL_RST;
      cv_q    <= CV_RST;
      ho_q    <= 1'b0;
    end else begin
      lives_q <= lives_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      cl_q    <= (lives_d == '0);
      cv_q    <= (level_d == LVL_MAX);
      ho_q    <= (hold_d != '0);
    end
  end

  assign SC_LIVESLEVELS_lives_Out                 = lives_q;
  assign SC_LIVESLEVELS_level_Out                 = level_q;
  assign SC_STATEMACHINEGENERAL_COMPARATOR_LIVES  = cl_q;
  assign SC_STATEMACHINEGENERAL_COMPARATOR_LEVELS = cv_q;
  assign SC_LIVESLEVELS_holdoff_Out               = ho_q;

endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Bench for sc_lives_levels_counter.
// Directed scenarios plus random strobes against a cycle model.
`timescale 1ns/1ps
module tb_sc_lives_levels_counter;

  localparam int L_INIT = 3;
  localparam int L_MAX  = 4;
  localparam int HOLD   = 8;

  logic       clk;
  logic       rst;
  logic       clr_n;
  logic       dec_n;
  logic       inc_n;
  logic [2:0] lives;
  logic [2:0] level;
  logic       cl;
  logic       cv;
  logic       ho;

  int n_tests;
  int n_fail;

  int m_lives;
  int m_level;
  int m_hold;
  bit m_pd;
  bit m_pi;

  sc_lives_levels_counter dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50          (clk),
    .SC_STATEMACHINEGENERAL_RESET_InHigh      (rst),
    .SC_LIVESLEVELS_clear_InLow               (clr_n),
    .SC_LIVESLEVELS_livesDec_InLow            (dec_n),
    .SC_LIVESLEVELS_levelInc_InLow            (inc_n),
    .SC_LIVESLEVELS_lives_Out                 (lives),
    .SC_LIVESLEVELS_level_Out                 (level),
    .SC_STATEMACHINEGENERAL_COMPARATOR_LIVES  (cl),
    .SC_STATEMACHINEGENERAL_COMPARATOR_LEVELS (cv),
    .SC_LIVESLEVELS_holdoff_Out               (ho)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("lives", int'(lives), m_lives);
    check("level", int'(level), m_level);
    check("cmp_lives", int'(cl), int'(m_lives == 0));
    check("cmp_levels", int'(cv), int'(m_level == L_MAX));
    check("holdoff", int'(ho), int'(m_hold != 0));
  endtask

  // One clock: drive at negedge, advance model, compare at next negedge.
  task automatic cyc(input bit c, input bit d, input bit i);
    bit ed;
    bit ei;
    clr_n = c;
    dec_n = d;
    inc_n = i;
    ed = m_pd && !d;
    ei = m_pi && !i;
    if (!c) begin
      m_lives = L_INIT;
      m_level = 0;
      m_hold  = 0;
    end else begin
      if (ed && m_lives > 0 && m_hold == 0) begin
        m_lives = m_lives - 1;
        m_hold  = HOLD;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end
      if (ei && m_level < L_MAX)
        m_level = m_level + 1;
    end
    m_pd = d;
    m_pi = i;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b1);
  endtask

  // Async reset from the middle of a low phase, checked before any edge.
  task automatic do_reset();
    dec_n = 1'b1;
    inc_n = 1'b1;
    clr_n = 1'b1;
    #3;
    rst = 1'b1;
    #2;
    m_lives = L_INIT;
    m_level = 0;
    m_hold  = 0;
    m_pd    = 1'b1;
    m_pi    = 1'b1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int hc;
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    clr_n = 1'b1;
    dec_n = 1'b1;
    inc_n = 1'b1;
    m_lives = L_INIT;
    m_level = 0;
    m_hold  = 0;
    m_pd    = 1'b1;
    m_pi    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("rst_lives", int'(lives), 3);
    check("rst_level", int'(level), 0);
    check("rst_hold", int'(ho), 0);

    // Held collision costs one life; holdoff lasts HOLD cycles.
    hc = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (k == 0) check("dec_lat", int'(lives), 2);
      hc += int'(ho);
    end
    check("held_lives", int'(lives), 2);
    check("hold_len", hc, HOLD);
    idle(2);

    // Four spaced pulses: 3->2->1->0 then saturate.
    cyc(1'b0, 1'b1, 1'b1);
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (p == 2) check("zero_flag", int'(cl), 1);
      idle(9);
    end
    check("sat_lives", int'(lives), 0);
    check("sat_hold", int'(ho), 0);

    // Pulse inside holdoff is dropped; one at offset 9 is taken.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("drop_in_hold", int'(lives), 2);
    idle(6);
    cyc(1'b1, 1'b0, 1'b1);
    check("after_hold", int'(lives), 1);
    idle(10);

    // Level climbs to the maximum and sticks.
    cyc(1'b0, 1'b1, 1'b1);
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, 1'b1, 1'b0);
      check("lvl_step", int'(level), (p < 4) ? p + 1 : 4);
      cyc(1'b1, 1'b1, 1'b1);
    end
    check("lvl_flag", int'(cv), 1);

    // Simultaneous inc and dec both apply.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    check("both_level", int'(level), 3);
    check("both_lives", int'(lives), 2);
    idle(10);

    // Clear with dec held low, released while still low.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("clr_rel_lives", int'(lives), 3);
    check("clr_rel_level", int'(level), 0);
    cyc(1'b1, 1'b1, 1'b1);

    // Async reset mid-holdoff.
    cyc(1'b1, 1'b0, 1'b1);
    idle(3);
    do_reset();
    check("arst_lives", int'(lives), 3);
    check("arst_hold", int'(ho), 0);
    idle(2);

    // Random strobes against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 59) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
